// File: rtl/mem_line_ctrl.sv
// rtl/mem_line_ctrl.sv - cache line fill/writeback sequencer over a word-wide memory port
// Optional feature macro: MEM_LINE_CTRL_TIMEOUT_EN (per-word wait timeout reported on error_o)
module mem_line_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 64,
    parameter int WORDS_PER_LINE = 16
) (
    input  logic                                 clk_i,
    input  logic                                 arstn_i,
    input  logic                                 start_i,
    input  logic                                 write_i,
    input  logic [ADDR_WIDTH-1:0]                line_addr_i,
    input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] wdata_line_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] rdata_line_o,
    output logic                                 mem_read_request_o,
    output logic                                 mem_write_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_data_o,
    input  logic [DATA_WIDTH-1:0]                mem_read_data_i,
    input  logic                                 mem_successful_access_i
);

    localparam int LINE_BITS  = WORDS_PER_LINE * DATA_WIDTH;
    localparam int IDX_W      = $clog2(WORDS_PER_LINE);
    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int LINE_BYTES = WORDS_PER_LINE * WORD_BYTES;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_write;
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_rdata;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_access;
    logic                  w_ack;
    logic                  w_last;
    logic                  w_start;
    logic                  w_timeout;
    logic [31:0]           w_word_lsb;

    assign w_access   = (r_state == S_ACCESS);
    assign w_ack      = w_access && mem_successful_access_i;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_start    = (r_state == S_IDLE) && start_i;
    assign w_word_lsb = 32'(r_idx) * 32'(DATA_WIDTH);

`ifdef MEM_LINE_CTRL_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_err;

    // The 255th consecutive unacknowledged cycle of a word ends the transfer with an error
    assign w_timeout = w_access && !mem_successful_access_i && (r_wait == 8'hFE);

    // Per-word wait counter and sticky error flag for the DONE cycle
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wait <= 8'h00;
            r_err  <= 1'b0;
        end else if (w_start) begin
            r_wait <= 8'h00;
            r_err  <= 1'b0;
        end else if (w_ack) begin
            r_wait <= 8'h00;
        end else if (w_access) begin
            r_wait <= r_wait + 8'd1;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign done_o  = (r_state == S_DONE) && !r_err;
    assign error_o = (r_state == S_DONE) && r_err;
`else
    assign w_timeout = 1'b0;
    assign done_o    = (r_state == S_DONE);
    assign error_o   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE always lasts exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_state_nxt = S_ACCESS;
            S_ACCESS: if ((w_ack && w_last) || w_timeout) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer context latch, word index advance and fill capture
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_base  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_idx   <= '0;
        end else if (w_start) begin
            r_base  <= line_addr_i & ~LINE_MASK;
            r_write <= write_i;
            r_wdata <= wdata_line_i;
            r_idx   <= '0;
        end else if (w_ack) begin
            if (!r_write) begin
                r_rdata[w_word_lsb +: DATA_WIDTH] <= mem_read_data_i;
            end
            r_idx <= r_idx + 1'b1;
        end
    end

    // Request outputs are pure decodes of registered state, so they are quiet outside ACCESS
    assign busy_o             = (r_state != S_IDLE);
    assign mem_read_request_o = w_access && !r_write;
    assign mem_write_en_o     = w_access && r_write;
    assign mem_addr_o         = w_access ? (r_base + (ADDR_WIDTH'(r_idx) << WORD_SHIFT)) : '0;
    assign mem_data_o         = w_access ? r_wdata[w_word_lsb +: DATA_WIDTH] : '0;
    assign rdata_line_o       = r_rdata;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb/tb_mem_line_ctrl.sv - randomized model-checked bench for mem_line_ctrl
module tb_mem_line_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 64;
    localparam int WPL = 16;
    localparam int LB  = DW * WPL;

    logic          clk = 1'b0;
    logic          arstn_i = 1'b1;
    logic          start_i = 1'b0;
    logic          write_i = 1'b0;
    logic [AW-1:0] line_addr_i = '0;
    logic [LB-1:0] wdata_line_i = '0;
    logic          busy_o, done_o, error_o;
    logic [LB-1:0] rdata_line_o;
    logic          mem_read_request_o, mem_write_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_read_data_i = '0;
    logic          mem_successful_access_i = 1'b0;

    always #5 clk = ~clk;

    mem_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL)) dut (
        .clk_i(clk), .arstn_i(arstn_i), .start_i(start_i), .write_i(write_i),
        .line_addr_i(line_addr_i), .wdata_line_i(wdata_line_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .rdata_line_o(rdata_line_o),
        .mem_read_request_o(mem_read_request_o), .mem_write_en_o(mem_write_en_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_data_i(mem_read_data_i), .mem_successful_access_i(mem_successful_access_i)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory image, 4096 words, aliased on byte address bits [13:2]
    logic [31:0] mem [0:4095];
    function automatic int widx(input logic [63:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int k = 0; k < WPL; k++) r[k*DW +: DW] = $urandom;
        return r;
    endfunction

    // Inputs as the DUT saw them at the last rising edge
    int            cyc = 0;
    logic          s_rstn = 1'b0, s_start = 1'b0, s_write = 1'b0, s_ack = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [LB-1:0] s_wdata = '0;
    logic [DW-1:0] s_rdata = '0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_rstn  <= arstn_i;
        s_start <= start_i;
        s_write <= write_i;
        s_addr  <= line_addr_i;
        s_wdata <= wdata_line_i;
        s_ack   <= mem_successful_access_i;
        s_rdata <= mem_read_data_i;
    end

    // Transfer-level model: in flight, words completed, finishing cycle, expected line
    bit            m_busy = 0, m_fin = 0, m_err = 0, m_write = 0;
    int            m_k = 0, m_wait = 0;
    logic [63:0]   m_base = '0;
    logic [31:0]   m_wl [WPL];
    logic [31:0]   m_rl [WPL];

    task automatic model_clear();
        m_busy = 0; m_fin = 0; m_err = 0; m_write = 0; m_k = 0; m_wait = 0; m_base = '0;
        for (int k = 0; k < WPL; k++) begin m_wl[k] = '0; m_rl[k] = '0; end
    endtask

    task automatic model_step();
        if (m_fin) begin
            m_fin = 0; m_busy = 0; m_err = 0;
        end else if (m_busy) begin
            if (s_ack) begin
                if (!m_write) m_rl[m_k] = s_rdata;
                m_k++;
                m_wait = 0;
                if (m_k == WPL) m_fin = 1;
            end else begin
`ifdef MEM_LINE_CTRL_TIMEOUT_EN
                m_wait++;
                if (m_wait == 255) begin m_fin = 1; m_err = 1; end
`endif
            end
        end else if (s_start) begin
            m_busy = 1; m_k = 0; m_wait = 0; m_write = s_write;
            m_base = s_addr & ~64'h3F;
            for (int k = 0; k < WPL; k++) m_wl[k] = s_wdata[k*DW +: DW];
        end
    endtask

    // Memory responder configuration and state
    int cur_lat = -1, wcnt = 0, lat_lo = 0, lat_hi = 0, total_waits = 0;
    bit never_ack = 0;

    task automatic respond();
        bit ack;
        ack = 0;
        if (arstn_i && (mem_read_request_o || mem_write_en_o)) begin
            if (!never_ack) begin
                if (cur_lat < 0) cur_lat = $urandom_range(lat_hi, lat_lo);
                if (wcnt == cur_lat) begin
                    ack = 1; wcnt = 0; cur_lat = -1;
                    if (mem_write_en_o) begin
                        mem[widx(mem_addr_o)] = mem_data_o;
                        mem_read_data_i = $urandom;
                    end else begin
                        mem_read_data_i = mem[widx(mem_addr_o)];
                    end
                end else begin
                    wcnt++; total_waits++;
                    mem_read_data_i = $urandom;
                end
            end
        end else begin
            cur_lat = -1; wcnt = 0;
            ack = ($urandom_range(1, 0) == 1);
            mem_read_data_i = $urandom;
        end
        mem_successful_access_i = ack;
    endtask

    bit          pend_prev = 0;
    logic [63:0] addr_prev = '0;
    logic [31:0] data_prev = '0;

    // Per-cycle comparison of every output against the model, then drive the memory side
    task automatic cycle_check();
        logic [LB-1:0] exp_line;
        logic [63:0]   ea;
        logic [31:0]   ed;
        bit            acc, req;
        if (!arstn_i) model_clear();
        else if (s_rstn) model_step();
        acc = m_busy && !m_fin;
        for (int k = 0; k < WPL; k++) exp_line[k*DW +: DW] = m_rl[k];
        ea = '0; ed = '0;
        if (acc) begin
            ea = m_base + 64'(4 * m_k);
            ed = m_wl[m_k];
        end
        chk("busy", busy_o, m_busy);
        chk("done", done_o, m_fin && !m_err);
        chk("error", error_o, m_fin && m_err);
        chk("rd_req", mem_read_request_o, acc && !m_write);
        chk("wr_en", mem_write_en_o, acc && m_write);
        chk("addr", mem_addr_o, ea);
        chk("wdata", mem_data_o, ed);
        chk("rline", rdata_line_o, exp_line);
        req = mem_read_request_o || mem_write_en_o;
        if (pend_prev && req) begin
            chk("addr_stable", mem_addr_o, addr_prev);
            chk("data_stable", mem_data_o, data_prev);
        end
        respond();
        pend_prev = arstn_i && req && !mem_successful_access_i;
        addr_prev = mem_addr_o;
        data_prev = mem_data_o;
    endtask

    logic [63:0] obs_addr [$];

    task automatic run_xfer(input bit wr, input logic [63:0] a, input logic [LB-1:0] wl,
                            input int budget, output int lat);
        int s;
        bit seen;
        @(negedge clk);
        write_i = wr; line_addr_i = a; wdata_line_i = wl; start_i = 1'b1;
        s = cyc; total_waits = 0; obs_addr.delete();
        seen = 0; lat = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start_i = 1'b0; write_i = $urandom_range(1, 0);
                line_addr_i = {$urandom, $urandom}; wdata_line_i = rand_line();
            end
            if (mem_read_request_o || mem_write_en_o) obs_addr.push_back(mem_addr_o);
            if (done_o || error_o) begin seen = 1; lat = cyc - s; end
        end
        chk("xfer_completes", 512'(seen), 512'(1));
    endtask

    initial begin
        int lat, s, cnt;
        int dq [$];
        logic [31:0] img [WPL];
        logic [LB-1:0] wl;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        model_clear();
        fork
            forever begin
                @(negedge clk);
                cycle_check();
            end
        join_none
        #1 arstn_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd", mem_read_request_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_rline", rdata_line_o, 0);
        @(negedge clk);
        #2 arstn_i = 1'b1;

        // Zero-wait fill of line 0x1040
        lat_lo = 0; lat_hi = 0;
        run_xfer(1'b0, 64'h1044, rand_line(), 200, lat);
        chk("A_latency", lat, 17);
        chk("A_nwords", obs_addr.size(), 16);
        for (int k = 0; k < obs_addr.size() && k < WPL; k++)
            chk("A_addr_seq", obs_addr[k], 64'h1040 + 64'(4 * k));
        for (int k = 0; k < WPL; k++)
            chk("A_rline_word", rdata_line_o[k*DW +: DW], mem[widx(64'h1040 + 64'(4 * k))]);

        // Writeback with 3 wait cycles per word
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < WPL; k++) wl[k*DW +: DW] = 32'hA500_0000 + 32'(k);
        run_xfer(1'b1, 64'h2000, wl, 200, lat);
        chk("B_latency", lat, 65);
        for (int k = 0; k < WPL; k++) begin
            cnt = 0;
            foreach (obs_addr[i]) if (obs_addr[i] == 64'h2000 + 64'(4 * k)) cnt++;
            chk("B_hold_cycles", cnt, 4);
            chk("B_mem_word", mem[widx(64'h2000 + 64'(4 * k))], 32'hA500_0000 + 32'(k));
        end

        // Long random latency: fill then write the same image back
        lat_lo = 0; lat_hi = 254;
        for (int k = 0; k < WPL; k++) img[k] = mem[widx(64'h3000 + 64'(4 * k))];
        run_xfer(1'b0, 64'h3024, rand_line(), 5000, lat);
        chk("C_fill_latency", lat, WPL + 1 + total_waits);
        for (int k = 0; k < WPL; k++) begin
            chk("C_rline_word", rdata_line_o[k*DW +: DW], img[k]);
            wl[k*DW +: DW] = img[k];
        end
        run_xfer(1'b1, 64'h3000 + 64'($urandom_range(63, 0)), wl, 5000, lat);
        chk("C_wb_latency", lat, WPL + 1 + total_waits);
        for (int k = 0; k < WPL; k++)
            chk("C_mem_unchanged", mem[widx(64'h3000 + 64'(4 * k))], img[k]);

        // start_i held high: back-to-back transfers separated by one IDLE cycle
        lat_lo = 0; lat_hi = 0;
        @(negedge clk);
        write_i = 1'b0; line_addr_i = 64'h1000; start_i = 1'b1; s = cyc;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_o) dq.push_back(cyc - s);
        end
        start_i = 1'b0;
        chk("D_done_count", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("D_done0", dq[0], 17);
            chk("D_done1", dq[1], 35);
            chk("D_done2", dq[2], 53);
        end
        cnt = 0;
        while (busy_o && cnt < 100) begin @(negedge clk); cnt++; end
        chk("D_back_idle", busy_o, 0);

        // Reset pulse at word 5 of a fill
        @(negedge clk);
        write_i = 1'b0; line_addr_i = 64'h1400; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cnt = 0;
        while (mem_addr_o != 64'h1414 && cnt < 50) begin @(negedge clk); cnt++; end
        chk("E_reached_word5", mem_addr_o, 64'h1414);
        #2 arstn_i = 1'b0;
        #1;
        chk("E_rst_busy", busy_o, 0);
        chk("E_rst_done", done_o, 0);
        chk("E_rst_err", error_o, 0);
        chk("E_rst_rd", mem_read_request_o, 0);
        chk("E_rst_wr", mem_write_en_o, 0);
        chk("E_rst_addr", mem_addr_o, 0);
        chk("E_rst_data", mem_data_o, 0);
        chk("E_rst_rline", rdata_line_o, 0);
        @(negedge clk);
        chk("E_no_done", done_o, 0);
        #2 arstn_i = 1'b1;
        run_xfer(1'b0, 64'h1400, rand_line(), 200, lat);
        chk("E_latency", lat, 17);
        chk("E_nwords", obs_addr.size(), 16);

        // Randomized transfers
        for (int t = 0; t < 25; t++) begin
            lat_lo = 0; lat_hi = $urandom_range(4, 0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            run_xfer($urandom_range(1, 0) == 1, {$urandom, $urandom}, rand_line(), 500, lat);
            chk("R_latency", lat, WPL + 1 + total_waits);
        end

`ifdef MEM_LINE_CTRL_TIMEOUT_EN
        never_ack = 1;
        run_xfer(1'b0, 64'h1000, rand_line(), 400, lat);
        chk("T_latency", lat, 256);
        chk("T_error", error_o, 1);
        chk("T_done_low", done_o, 0);
        @(negedge clk);
        chk("T_busy_drop", busy_o, 0);
        chk("T_error_once", error_o, 0);
        never_ack = 0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_line_ctrl.md
MEM_LINE_CTRL -- requirements
Module: mem_line_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning memory word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 64, meaning byte address width.
REQ-003 The block SHALL have parameter WORDS_PER_LINE, default 16, meaning words per cache line; it is a power of two, 2 or greater.
REQ-004 The block SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port arstn_i  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port start_i  input  1  line transfer request, sampled only in IDLE.
REQ-007 The block SHALL have port write_i  input  1  1 = line writeback, 0 = line fill; sampled with start_i.
REQ-008 The block SHALL have port line_addr_i  input  ADDR_WIDTH  byte address inside the target line; sampled with start_i.
REQ-009 The block SHALL have port wdata_line_i  input  WORDS_PER_LINE*DATA_WIDTH  writeback line; word k is bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; sampled with start_i.
REQ-010 The block SHALL have port busy_o  output  1  high in ACCESS and DONE.
REQ-011 The block SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port error_o  output  1  one-cycle timeout pulse.
REQ-013 The block SHALL have port rdata_line_o  output  WORDS_PER_LINE*DATA_WIDTH  last filled line, same word packing as wdata_line_i.
REQ-014 The block SHALL have port mem_read_request_o  output  1  word read request to memory.
REQ-015 The block SHALL have port mem_write_en_o  output  1  word write request to memory.
REQ-016 The block SHALL have port mem_addr_o  output  ADDR_WIDTH  word byte address.
REQ-017 The block SHALL have port mem_data_o  output  DATA_WIDTH  word write data.
REQ-018 The block SHALL have port mem_read_data_i  input  DATA_WIDTH  memory read data; valid only in a cycle where mem_successful_access_i is high.
REQ-019 The block SHALL have port mem_successful_access_i  input  1  current word access completes this cycle.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and DONE: IDLE->ACCESS on start_i; ACCESS->DONE on completion of the last word; DONE->IDLE unconditionally after 1 cycle.
REQ-021 On start the block SHALL latch base = line_addr_i with its low log2(WORDS_PER_LINE*DATA_WIDTH/8) bits cleared, latch write_i and wdata_line_i, and clear the word index to 0.
REQ-022 In ACCESS, mem_addr_o SHALL equal base + index*(DATA_WIDTH/8), and mem_data_o SHALL equal latched word[index].
REQ-023 In ACCESS, exactly one of mem_read_request_o or mem_write_en_o SHALL be high, selected by the latched write_i, and held continuously with stable address and data until mem_successful_access_i.
REQ-024 On a cycle in ACCESS with mem_successful_access_i high, a fill SHALL capture mem_read_data_i into rdata_line_o word[index], and the index SHALL increment.
REQ-025 The next word's request SHALL follow in the next cycle with no idle gap; a zero-wait memory therefore gives 1 word per cycle.
REQ-026 mem_successful_access_i SHALL be ignored outside ACCESS.
REQ-027 Both memory request outputs SHALL be low in IDLE and DONE.
REQ-028 done_o SHALL be high only in DONE; its latency is WORDS_PER_LINE + total wait cycles + 1 after the start cycle.
REQ-029 start_i SHALL be ignored while busy_o is high, including in DONE; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-030 rdata_line_o SHALL be updated only by fill captures and SHALL hold its value across writebacks and idle periods.

Reset
REQ-031 When arstn_i is low, the block SHALL be in IDLE with index 0, and busy_o, done_o, error_o, mem_read_request_o, mem_write_en_o, mem_addr_o, mem_data_o and rdata_line_o all 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer immediately, with no done_o; words already written to memory are not rolled back.

Configuration
REQ-033 With MEM_LINE_CTRL_TIMEOUT_EN defined, an 8-bit per-word wait counter SHALL clear on each completed word; if it reaches 255 without mem_successful_access_i, the block SHALL drop its requests, pulse error_o for 1 cycle in DONE (with done_o low), then return to IDLE.
REQ-034 Without MEM_LINE_CTRL_TIMEOUT_EN, error_o SHALL be tied 0, no counter SHALL exist, and the block SHALL wait indefinitely.

Verification
REQ-035 Zero-wait memory, fill, line_addr_i=0x1044 -> mem_addr_o = 0x1040, 0x1044, ... 0x107C on consecutive cycles; done_o 17 cycles after start; rdata_line_o word k = mem[0x1040+4k].
REQ-036 Writeback, wdata word k = 0xA5000000+k, memory wait 3 cycles per word -> each address held 4 cycles with mem_write_en_o high; memory holds 0xA5000000..0xA500000F; done_o at cycle 65.
REQ-037 Memory with pseudo-random 1..255-cycle latency, fill then writeback of the same line -> rdata_line_o matches the preloaded image, the writeback leaves memory unchanged, and mem_addr_o/mem_data_o never change while a request is pending.
REQ-038 start_i held high continuously -> a new transfer begins only in the cycle after done_o, with no start accepted during ACCESS or DONE.
REQ-039 arstn_i pulsed low while at word index 5 of a fill -> all outputs 0 immediately, no done_o, and the next start runs a complete 16-word transfer.
REQ-040 With MEM_LINE_CTRL_TIMEOUT_EN defined, memory never acknowledges -> error_o pulses once 255 cycles into word 0, requests drop, and busy_o falls on the following cycle.
